// File: rtl/nonce_result_scanner_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the nonce result scanner: bus widths, read latency,
// FSM state codes and the layout of the summary word written after the hash block.
package nonce_result_scanner_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int MEM_RD_LAT = 2;

  localparam int FOUND_BIT  = 31;
  localparam int IDX_LSB    = 0;

  typedef logic [2:0] scanner_state_t;

  localparam scanner_state_t IDLE  = 3'd0;
  localparam scanner_state_t ISSUE = 3'd1;
  localparam scanner_state_t DRAIN = 3'd2;
  localparam scanner_state_t WRITE = 3'd3;
  localparam scanner_state_t DONE  = 3'd4;

  // idx must already be zero-extended and narrow enough to stay clear of FOUND_BIT.
  function automatic logic [DATA_W-1:0] pack_summary(input logic              found,
                                                     input logic [DATA_W-1:0] idx);
    logic [DATA_W-1:0] word;
    word            = idx << IDX_LSB;
    word[FOUND_BIT] = found;
    return word;
  endfunction

endpackage

// File: rtl/nonce_result_scanner_if.sv
`timescale 1ns/1ps
// Word-memory port shared by the scanner (master) and the synchronous RAM (slave).
import nonce_result_scanner_pkg::*;

interface nonce_result_scanner_if;

  logic              mem_clk;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output mem_clk,
    output mem_we,
    output mem_addr,
    output mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_clk,
    input  mem_we,
    input  mem_addr,
    input  mem_write_data,
    output mem_read_data
  );

endinterface

// File: rtl/nonce_result_scanner.sv
`timescale 1ns/1ps
// Streams NUM_NONCES hash words out of shared memory, tracks the smallest one and its
// index, and writes a {found, index} summary word just past the hash block.
import nonce_result_scanner_pkg::*;

module nonce_result_scanner #(
  parameter int NUM_NONCES = 16,
  parameter int IDX_W      = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      result_addr,
  input  logic [DATA_W-1:0]      target,
  output logic                   done,
  output logic                   found,
  output logic [IDX_W-1:0]       best_idx,
  output logic [DATA_W-1:0]      best_value,
  nonce_result_scanner_if.master mem
);

  localparam int CNT_W = $clog2(NUM_NONCES + 3);

  scanner_state_t          state_q, state_d;
  logic [CNT_W-1:0]        iss_cnt_q, iss_cnt_d;
  logic [CNT_W-1:0]        ret_cnt_q, ret_cnt_d;
  logic [MEM_RD_LAT-1:0]   rd_pipe_q, rd_pipe_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [DATA_W-1:0]       target_q, target_d;
  logic [DATA_W-1:0]       best_value_q, best_value_d;
  logic [IDX_W-1:0]        best_idx_q, best_idx_d;
  logic                    found_q, found_d;
  logic                    done_q, done_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic                    issue;
  logic                    hit_now;

  // rd_pipe tracks which cycles carry a read, so the tail bit marks a returning word.
  always_comb begin
    state_d      = state_q;
    iss_cnt_d    = iss_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    base_d       = base_q;
    target_d     = target_q;
    best_value_d = best_value_q;
    best_idx_d   = best_idx_q;
    found_d      = found_q;
    done_d       = done_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    issue        = 1'b0;
    hit_now      = (best_value_q < target_q);

    if (rd_pipe_q[MEM_RD_LAT-1]) begin
      if (mem.mem_read_data < best_value_q) begin
        best_value_d = mem.mem_read_data;
        best_idx_d   = IDX_W'(ret_cnt_q);
      end
      ret_cnt_d = ret_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = ISSUE;
          base_d       = result_addr;
          target_d     = target;
          done_d       = 1'b0;
          found_d      = 1'b0;
          best_value_d = '1;
          best_idx_d   = '0;
          iss_cnt_d    = CNT_W'(1);
          ret_cnt_d    = '0;
          mem_addr_d   = result_addr;
          issue        = 1'b1;
        end
      end

      ISSUE: begin
        if (iss_cnt_q < CNT_W'(NUM_NONCES)) begin
          mem_addr_d = base_q + ADDR_W'(iss_cnt_q);
          iss_cnt_d  = iss_cnt_q + 1'b1;
          issue      = 1'b1;
        end
        if (iss_cnt_q >= CNT_W'(NUM_NONCES - 1)) begin
          state_d = DRAIN;
        end
      end

      // Only leave once every in-flight word has been compared, so best_* is final here.
      DRAIN: begin
        if (ret_cnt_q == CNT_W'(NUM_NONCES)) begin
          state_d     = WRITE;
          found_d     = hit_now;
          mem_we_d    = 1'b1;
          mem_addr_d  = base_q + ADDR_W'(NUM_NONCES);
          mem_wdata_d = pack_summary(hit_now, DATA_W'(best_idx_q));
        end
      end

      WRITE: begin
        state_d = DONE;
        done_d  = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    rd_pipe_d = {rd_pipe_q[MEM_RD_LAT-2:0], issue};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      iss_cnt_q    <= '0;
      ret_cnt_q    <= '0;
      rd_pipe_q    <= '0;
      base_q       <= '0;
      target_q     <= '0;
      best_value_q <= '1;
      best_idx_q   <= '0;
      found_q      <= 1'b0;
      done_q       <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      iss_cnt_q    <= iss_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
      rd_pipe_q    <= rd_pipe_d;
      base_q       <= base_d;
      target_q     <= target_d;
      best_value_q <= best_value_d;
      best_idx_q   <= best_idx_d;
      found_q      <= found_d;
      done_q       <= done_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign done               = done_q;
  assign found              = found_q;
  assign best_idx           = best_idx_q;
  assign best_value         = best_value_q;

  assign mem.mem_clk        = clk;
  assign mem.mem_we         = mem_we_q;
  assign mem.mem_addr       = mem_addr_q;
  assign mem.mem_write_data = mem_wdata_q;

endmodule
